branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Execute-side writer/corrector for the fetch-side Branch_Target buffer. Carries each fetch's
//  prediction (Hit, Target_Add) down IF->ID->EX and compares it with the real outcome in EX.
//  On a misprediction it issues a flush, a fetch redirect and a BTB write/invalidate.
//  Keeps a 2-bit hysteresis counter per BTB entry and saturating branch/mispredict counters.
// PARAMETERS
//  WIDTH_DATA_LENGTH   32  PC/target width
//  WIDTH_ENTRY_LENGTH  3   BTB index bits; index = PC[WIDTH_ENTRY_LENGTH+1:2]
//  ENTRY_DEPTH_LENGTH  8   BTB entries (1<<WIDTH_ENTRY_LENGTH)
//  PERF_CNT_WIDTH      16  width of the performance counters
// PORTS
//  clk            in   1   clock, all state on posedge
//  rst            in   1   synchronous, active-high reset
//  PC             in   32  fetch PC, same cycle as BTB lookup
//  Hit            in   1   BTB hit for PC
//  Target_Add     in   32  BTB predicted target for PC
//  Stall_Detected in   1   hazard stall: hold IF/ID, bubble into ID/EX
//  PC_Ex          in   32  PC of instruction in EX
//  Br_Detected    in   1   instruction in EX is a branch/jump
//  Taken_Ex       in   1   branch in EX resolved taken (don't-care if !Br_Detected)
//  PC_ALU         in   32  resolved target from ALU
//  Flush          out  1   kill IF/ID and ID/EX contents
//  Redirect_En    out  1   fetch must load Redirect_PC next
//  Redirect_PC    out  32  corrected fetch address
//  Upd_En         out  1   BTB write strobe
//  Upd_Inval      out  1   with Upd_En: invalidate entry instead of writing
//  Upd_PC         out  32  BTB write PC (tag+index source)
//  Upd_Target     out  32  BTB write target
//  Br_Cnt         out  16  resolved branches, saturating
//  Mispred_Cnt    out  16  mispredictions, saturating
// BEHAVIOUR
//  Reset: all outputs 0, stage valids 0, counters 0, every 2-bit entry counter 0.
//  Metadata pipe {valid,hit,target}: IF/ID <= fetch inputs; ID/EX <= IF/ID. Priority per edge:
//   rst > Flush (both valids cleared) > Stall_Detected (IF/ID holds, ID/EX valid<=0) > advance.
//  EX evaluation enabled when ID/EX.valid & !Flush; otherwise no action.
//  Cases (p=ID/EX.hit, t=ID/EX.target, ctr=entry counter of PC_Ex):
//   Br&Taken&p&t==PC_ALU : correct; ctr sat-inc.
//   Br&Taken&!p          : mispred; redirect PC_ALU; write {PC_Ex,PC_ALU}; ctr<=2.
//   Br&Taken&p&t!=PC_ALU : mispred; redirect PC_ALU; rewrite target; ctr<=2.
//   Br&!Taken&p          : mispred; redirect PC_Ex+4; ctr sat-dec; Upd_Inval if new ctr<2.
//   Br&!Taken&!p         : correct; no action.
//   !Br&p (alias)        : mispred; redirect PC_Ex+4; invalidate; ctr<=0; not counted in Br_Cnt.
//  Latency: outputs registered, asserted exactly one cycle after EX evaluation, 1-cycle pulses.
//   Flush==Redirect_En always. Fetch uses Redirect_PC on the edge ending the Flush cycle.
//  PC_Ex+4 wraps modulo 2^32. Counters saturate at all-ones, never wrap.
//  Stall coincident with evaluation: EX still resolves; bubble inserted behind it.
//  Back-to-back mispredicts impossible: Flush gates the next EX evaluation.
//  Reset mid-flush: pending pulses dropped, outputs 0 next cycle.
// STRUCTURE
//  Shared package: BTB index/tag width localparams, 2-bit counter constants (SNT=0,WNT=1,WT=2,ST=3),
//   outcome-case encoding. Sub-module: br_hyst_table (ENTRY_DEPTH_LENGTH x 2-bit, 1 read/1 write,
//   synchronous reset) indexed by PC_Ex index bits.
// TESTING
//  1 BTB miss, branch at 0x1234_0000 taken to 0xFFFF_AAAA -> next cycle Flush=1, Redirect_PC=0xFFFF_AAAA,
//    Upd_En=1, Upd_Inval=0, Upd_PC=0x1234_0000, Upd_Target=0xFFFF_AAAA, Mispred_Cnt=1.
//  2 Hit target 0xFFFF_AAAA, taken to 0x1414_1414 -> Flush, redirect/rewrite 0x1414_1414, ctr=2.
//  3 Hit, not taken, PC_Ex=0x1234_0004, ctr=2 -> Redirect_PC=0x1234_0008, Upd_Inval=1, ctr=1;
//    repeat from ctr=3 -> redirect only, no invalidate.
//  4 Stall_Detected=1 with hit in IF/ID -> IF/ID holds, EX sees bubble, no outputs; resolves once after release.
//  5 Mispredict followed by a wrong-path hit in next EX cycle -> gated, single Flush pulse, Br_Cnt +1.
//  6 PC_Ex=0xFFFF_FFFC alias hit; rst asserted during Flush -> redirect 0x0000_0000; reset clears all.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : branch_resolve_unit_pkg                                         |
// | Brief  : Shared types and constants for the execute-side branch resolver |
// |          and its per-entry hysteresis table.                             |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package branch_resolve_unit_pkg;

  // Default geometry. The BTB index is taken from PC[IDX_LSB +: IDX_W].
  localparam int DATA_W  = 32;
  localparam int IDX_W   = 3;
  localparam int IDX_LSB = 2;
  localparam int DEPTH   = 1 << IDX_W;
  localparam int PERF_W  = 16;

  // 2-bit hysteresis counter values.
  typedef logic [1:0] ctr_t;
  localparam ctr_t CTR_SNT = 2'd0;
  localparam ctr_t CTR_WNT = 2'd1;
  localparam ctr_t CTR_WT  = 2'd2;
  localparam ctr_t CTR_ST  = 2'd3;

  // Outcome of one EX evaluation.
  typedef enum logic [2:0] {
    OC_NONE          = 3'd0,  // nothing to resolve (bubble, gated, or plain non-branch)
    OC_HIT_OK        = 3'd1,  // predicted taken, right target
    OC_MISS_TAKEN    = 3'd2,  // not predicted, actually taken
    OC_BAD_TARGET    = 3'd3,  // predicted taken, wrong target
    OC_BAD_NOT_TAKEN = 3'd4,  // predicted taken, actually not taken
    OC_NT_OK         = 3'd5,  // not predicted, not taken
    OC_ALIAS         = 3'd6   // BTB hit on a non-branch instruction
  } outcome_e;

  function automatic outcome_e classify_outcome(
    input logic eval_en,
    input logic br,
    input logic taken,
    input logic hit,
    input logic tgt_match
  );
    outcome_e oc;
    oc = OC_NONE;
    if (eval_en) begin
      if (!br) begin
        oc = hit ? OC_ALIAS : OC_NONE;
      end else if (taken) begin
        if (!hit)           oc = OC_MISS_TAKEN;
        else if (tgt_match) oc = OC_HIT_OK;
        else                oc = OC_BAD_TARGET;
      end else begin
        oc = hit ? OC_BAD_NOT_TAKEN : OC_NT_OK;
      end
    end
    return oc;
  endfunction

  function automatic ctr_t ctr_sat_inc(input ctr_t c);
    return (c == CTR_ST) ? CTR_ST : c + 2'd1;
  endfunction

  function automatic ctr_t ctr_sat_dec(input ctr_t c);
    return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

endpackage : branch_resolve_unit_pkg
`default_nettype wire

// File: rtl/branch_resolve_unit_br_hyst_table.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : br_hyst_table                                                   |
// | Brief  : ENTRY_DEPTH x 2-bit hysteresis counters, one asynchronous read  |
// |          port and one synchronous write port, synchronous reset to SNT.  |
// | Ports  : clk, rst         clock / sync active-high reset                 |
// |          rd_idx, rd_ctr   combinational read                             |
// |          wr_en, wr_idx,   write strobe, index, data (applied on posedge) |
// |          wr_ctr                                                          |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module br_hyst_table
  import branch_resolve_unit_pkg::*;
#(
  parameter int ENTRY_W     = IDX_W,
  parameter int ENTRY_DEPTH = DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ENTRY_W-1:0] rd_idx,
  output logic [1:0]         rd_ctr,
  input  logic               wr_en,
  input  logic [ENTRY_W-1:0] wr_idx,
  input  logic [1:0]         wr_ctr
);

  ctr_t ctr_q [ENTRY_DEPTH];
  ctr_t ctr_d [ENTRY_DEPTH];

  always_comb begin
    ctr_d = ctr_q;
    if (wr_en) begin
      ctr_d[wr_idx] = wr_ctr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < ENTRY_DEPTH; e++) begin
        ctr_q[e] <= CTR_SNT;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign rd_ctr = ctr_q[rd_idx];

endmodule : br_hyst_table
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : branch_resolve_unit                                             |
// | Brief  : Carries each fetch's BTB prediction through IF/ID and ID/EX,    |
// |          compares it with the real outcome in EX and, on a mispredict,   |
// |          issues a one-cycle flush/redirect plus a BTB write/invalidate.  |
// |          Also keeps per-entry hysteresis and saturating perf counters.   |
// | Ports  : clk, rst                 clock / sync active-high reset         |
// |          PC, Hit, Target_Add      fetch-side BTB lookup result           |
// |          Stall_Detected           hold IF/ID, bubble into ID/EX          |
// |          PC_Ex, Br_Detected,      real outcome of the instruction in EX  |
// |          Taken_Ex, PC_ALU                                                |
// |          Flush, Redirect_En,      pipeline kill and fetch redirect       |
// |          Redirect_PC                                                     |
// |          Upd_En, Upd_Inval,       BTB write / invalidate request         |
// |          Upd_PC, Upd_Target                                              |
// |          Br_Cnt, Mispred_Cnt      saturating performance counters        |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int WIDTH_DATA_LENGTH  = DATA_W,
  parameter int WIDTH_ENTRY_LENGTH = IDX_W,
  parameter int ENTRY_DEPTH_LENGTH = DEPTH,
  parameter int PERF_CNT_WIDTH     = PERF_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH_DATA_LENGTH-1:0]  PC,
  input  logic                          Hit,
  input  logic [WIDTH_DATA_LENGTH-1:0]  Target_Add,
  input  logic                          Stall_Detected,
  input  logic [WIDTH_DATA_LENGTH-1:0]  PC_Ex,
  input  logic                          Br_Detected,
  input  logic                          Taken_Ex,
  input  logic [WIDTH_DATA_LENGTH-1:0]  PC_ALU,
  output logic                          Flush,
  output logic                          Redirect_En,
  output logic [WIDTH_DATA_LENGTH-1:0]  Redirect_PC,
  output logic                          Upd_En,
  output logic                          Upd_Inval,
  output logic [WIDTH_DATA_LENGTH-1:0]  Upd_PC,
  output logic [WIDTH_DATA_LENGTH-1:0]  Upd_Target,
  output logic [PERF_CNT_WIDTH-1:0]     Br_Cnt,
  output logic [PERF_CNT_WIDTH-1:0]     Mispred_Cnt
);

  localparam int DW = WIDTH_DATA_LENGTH;
  localparam int PW = PERF_CNT_WIDTH;

  // Prediction metadata pipe
  logic          ifid_valid_q, ifid_valid_d;
  logic          ifid_hit_q,   ifid_hit_d;
  logic [DW-1:0] ifid_target_q, ifid_target_d;
  logic          idex_valid_q, idex_valid_d;
  logic          idex_hit_q,   idex_hit_d;
  logic [DW-1:0] idex_target_q, idex_target_d;

  // Registered outputs
  logic          flush_q,       flush_d;
  logic [DW-1:0] redirect_pc_q, redirect_pc_d;
  logic          upd_en_q,      upd_en_d;
  logic          upd_inval_q,   upd_inval_d;
  logic [DW-1:0] upd_pc_q,      upd_pc_d;
  logic [DW-1:0] upd_target_q,  upd_target_d;
  logic [PW-1:0] br_cnt_q,      br_cnt_d;
  logic [PW-1:0] mispred_cnt_q, mispred_cnt_d;

  // EX evaluation
  logic                          eval_en;
  outcome_e                      outcome;
  logic [DW-1:0]                 pc_ex_plus4;
  logic [WIDTH_ENTRY_LENGTH-1:0] idx_ex;
  ctr_t                          ctr_rd;
  logic                          ctr_we;
  ctr_t                          ctr_wdata;

  // The fetch PC itself is not needed: the EX-stage PC is supplied directly.
  logic unused_fetch_pc;
  assign unused_fetch_pc = ^PC;

  function automatic logic [PW-1:0] perf_inc(input logic [PW-1:0] c);
    return (&c) ? c : c + PW'(1);
  endfunction

  assign idx_ex = PC_Ex[WIDTH_ENTRY_LENGTH+IDX_LSB-1:IDX_LSB];

  br_hyst_table #(
    .ENTRY_W     (WIDTH_ENTRY_LENGTH),
    .ENTRY_DEPTH (ENTRY_DEPTH_LENGTH)
  ) u_hyst (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (idx_ex),
    .rd_ctr (ctr_rd),
    .wr_en  (ctr_we),
    .wr_idx (idx_ex),
    .wr_ctr (ctr_wdata)
  );

  // Pipe advance: an outstanding Flush kills both stages; a stall holds IF/ID
  // and drops a bubble into ID/EX.
  always_comb begin
    ifid_valid_d  = ifid_valid_q;
    ifid_hit_d    = ifid_hit_q;
    ifid_target_d = ifid_target_q;
    idex_valid_d  = idex_valid_q;
    idex_hit_d    = idex_hit_q;
    idex_target_d = idex_target_q;
    if (flush_q) begin
      ifid_valid_d = 1'b0;
      idex_valid_d = 1'b0;
    end else if (Stall_Detected) begin
      idex_valid_d = 1'b0;
    end else begin
      ifid_valid_d  = 1'b1;
      ifid_hit_d    = Hit;
      ifid_target_d = Target_Add;
      idex_valid_d  = ifid_valid_q;
      idex_hit_d    = ifid_hit_q;
      idex_target_d = ifid_target_q;
    end
  end

  // Resolution. While Flush is high the ID/EX contents are wrong-path, so
  // evaluation is gated; this also rules out back-to-back mispredicts.
  always_comb begin
    eval_en     = idex_valid_q & ~flush_q;
    outcome     = classify_outcome(eval_en, Br_Detected, Taken_Ex, idex_hit_q,
                                   (idex_target_q == PC_ALU));
    pc_ex_plus4 = PC_Ex + DW'(4);

    flush_d       = 1'b0;
    redirect_pc_d = '0;
    upd_en_d      = 1'b0;
    upd_inval_d   = 1'b0;
    upd_pc_d      = '0;
    upd_target_d  = '0;
    ctr_we        = 1'b0;
    ctr_wdata     = ctr_rd;
    br_cnt_d      = br_cnt_q;
    mispred_cnt_d = mispred_cnt_q;

    case (outcome)
      OC_HIT_OK: begin
        ctr_we    = 1'b1;
        ctr_wdata = ctr_sat_inc(ctr_rd);
      end
      OC_MISS_TAKEN, OC_BAD_TARGET: begin
        flush_d       = 1'b1;
        redirect_pc_d = PC_ALU;
        upd_en_d      = 1'b1;
        upd_pc_d      = PC_Ex;
        upd_target_d  = PC_ALU;
        ctr_we        = 1'b1;
        ctr_wdata     = CTR_WT;
      end
      OC_BAD_NOT_TAKEN: begin
        flush_d       = 1'b1;
        redirect_pc_d = pc_ex_plus4;
        ctr_we        = 1'b1;
        ctr_wdata     = ctr_sat_dec(ctr_rd);
        // Only drop the BTB entry once the counter leans not-taken.
        if (ctr_wdata <= CTR_WNT) begin
          upd_en_d    = 1'b1;
          upd_inval_d = 1'b1;
          upd_pc_d    = PC_Ex;
        end
      end
      OC_ALIAS: begin
        flush_d       = 1'b1;
        redirect_pc_d = pc_ex_plus4;
        upd_en_d      = 1'b1;
        upd_inval_d   = 1'b1;
        upd_pc_d      = PC_Ex;
        ctr_we        = 1'b1;
        ctr_wdata     = CTR_SNT;
      end
      default: ;
    endcase

    if (eval_en && Br_Detected) begin
      br_cnt_d = perf_inc(br_cnt_q);
    end
    if (flush_d) begin
      mispred_cnt_d = perf_inc(mispred_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_valid_q  <= 1'b0;
      ifid_hit_q    <= 1'b0;
      ifid_target_q <= '0;
      idex_valid_q  <= 1'b0;
      idex_hit_q    <= 1'b0;
      idex_target_q <= '0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      upd_en_q      <= 1'b0;
      upd_inval_q   <= 1'b0;
      upd_pc_q      <= '0;
      upd_target_q  <= '0;
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      ifid_valid_q  <= ifid_valid_d;
      ifid_hit_q    <= ifid_hit_d;
      ifid_target_q <= ifid_target_d;
      idex_valid_q  <= idex_valid_d;
      idex_hit_q    <= idex_hit_d;
      idex_target_q <= idex_target_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
      upd_en_q      <= upd_en_d;
      upd_inval_q   <= upd_inval_d;
      upd_pc_q      <= upd_pc_d;
      upd_target_q  <= upd_target_d;
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign Flush       = flush_q;
  assign Redirect_En = flush_q;
  assign Redirect_PC = redirect_pc_q;
  assign Upd_En      = upd_en_q;
  assign Upd_Inval   = upd_inval_q;
  assign Upd_PC      = upd_pc_q;
  assign Upd_Target  = upd_target_q;
  assign Br_Cnt      = br_cnt_q;
  assign Mispred_Cnt = mispred_cnt_q;

endmodule : branch_resolve_unit
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_branch_resolve_unit                                          |
// | Brief  : Directed self-checking bench for branch_resolve_unit.           |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst;
  logic [31:0] PC;
  logic        Hit;
  logic [31:0] Target_Add;
  logic        Stall_Detected;
  logic [31:0] PC_Ex;
  logic        Br_Detected;
  logic        Taken_Ex;
  logic [31:0] PC_ALU;
  logic        Flush;
  logic        Redirect_En;
  logic [31:0] Redirect_PC;
  logic        Upd_En;
  logic        Upd_Inval;
  logic [31:0] Upd_PC;
  logic [31:0] Upd_Target;
  logic [15:0] Br_Cnt;
  logic [15:0] Mispred_Cnt;

  int n_checks = 0;
  int n_errors = 0;

  branch_resolve_unit dut (
    .clk            (clk),
    .rst            (rst),
    .PC             (PC),
    .Hit            (Hit),
    .Target_Add     (Target_Add),
    .Stall_Detected (Stall_Detected),
    .PC_Ex          (PC_Ex),
    .Br_Detected    (Br_Detected),
    .Taken_Ex       (Taken_Ex),
    .PC_ALU         (PC_ALU),
    .Flush          (Flush),
    .Redirect_En    (Redirect_En),
    .Redirect_PC    (Redirect_PC),
    .Upd_En         (Upd_En),
    .Upd_Inval      (Upd_Inval),
    .Upd_PC         (Upd_PC),
    .Upd_Target     (Upd_Target),
    .Br_Cnt         (Br_Cnt),
    .Mispred_Cnt    (Mispred_Cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic [31:0] tgt;
    logic        br;
    logic        taken;
    logic [31:0] pc_ex;
    logic [31:0] pc_alu;
    logic        e_flush;
    logic [31:0] e_rpc;
    logic        e_upd;
    logic        e_inval;
    logic [31:0] e_upc;
    logic [31:0] e_utgt;
    logic [15:0] e_br;
    logic [15:0] e_mis;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compares the output bundle; payload fields are only meaningful while
  // their strobe is expected high (target only for a write, not an invalidate).
  task automatic check_out(input string tag, input logic e_flush, input logic [31:0] e_rpc,
                           input logic e_upd, input logic e_inval, input logic [31:0] e_upc,
                           input logic [31:0] e_utgt, input logic [15:0] e_br,
                           input logic [15:0] e_mis);
    check({tag, ".Flush"},       32'(Flush),       32'(e_flush));
    check({tag, ".Redirect_En"}, 32'(Redirect_En), 32'(e_flush));
    if (e_flush) check({tag, ".Redirect_PC"}, Redirect_PC, e_rpc);
    check({tag, ".Upd_En"},      32'(Upd_En),      32'(e_upd));
    if (e_upd) begin
      check({tag, ".Upd_Inval"}, 32'(Upd_Inval), 32'(e_inval));
      check({tag, ".Upd_PC"},    Upd_PC,         e_upc);
      if (!e_inval) check({tag, ".Upd_Target"}, Upd_Target, e_utgt);
    end
    check({tag, ".Br_Cnt"},      32'(Br_Cnt),      32'(e_br));
    check({tag, ".Mispred_Cnt"}, 32'(Mispred_Cnt), 32'(e_mis));
  endtask

  task automatic idle_inputs();
    Hit            = 1'b0;
    Target_Add     = 32'h0;
    Stall_Detected = 1'b0;
    Br_Detected    = 1'b0;
    Taken_Ex       = 1'b0;
    PC_ALU         = 32'h0;
  endtask

  // Fetch the prediction, let it travel two stages, resolve it in EX,
  // check the pulse, then check it is gone one cycle later.
  task automatic run_vec(input string tag, input vec_t v);
    idle_inputs();
    Hit        = v.hit;
    Target_Add = v.tgt;
    tick();
    idle_inputs();
    tick();
    PC_Ex       = v.pc_ex;
    Br_Detected = v.br;
    Taken_Ex    = v.taken;
    PC_ALU      = v.pc_alu;
    tick();
    check_out(tag, v.e_flush, v.e_rpc, v.e_upd, v.e_inval, v.e_upc, v.e_utgt, v.e_br, v.e_mis);
    idle_inputs();
    tick();
    check_out({tag, ".after"}, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, v.e_br, v.e_mis);
  endtask

  initial begin
    //            hit   tgt            br    tk    pc_ex          pc_alu         flush rpc            upd   inv   upc            utgt           br     mis
    vecs[0]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h1234_0000, 32'hFFFF_AAAA, 1'b1, 32'hFFFF_AAAA, 1'b1, 1'b0, 32'h1234_0000, 32'hFFFF_AAAA, 16'd1,  16'd1};
    vecs[1]  = '{1'b1, 32'hFFFF_AAAA, 1'b1, 1'b1, 32'h1234_0000, 32'h1414_1414, 1'b1, 32'h1414_1414, 1'b1, 1'b0, 32'h1234_0000, 32'h1414_1414, 16'd2,  16'd2};
    vecs[2]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h1234_0004, 32'h2000_0000, 1'b1, 32'h2000_0000, 1'b1, 1'b0, 32'h1234_0004, 32'h2000_0000, 16'd3,  16'd3};
    vecs[3]  = '{1'b1, 32'h2000_0000, 1'b1, 1'b0, 32'h1234_0004, 32'h2000_0000, 1'b1, 32'h1234_0008, 1'b1, 1'b1, 32'h1234_0004, 32'h0,         16'd4,  16'd4};
    vecs[4]  = '{1'b1, 32'h2000_0000, 1'b1, 1'b1, 32'h1234_0004, 32'h2000_0000, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         16'd5,  16'd4};
    vecs[5]  = '{1'b1, 32'h2000_0000, 1'b1, 1'b1, 32'h1234_0004, 32'h2000_0000, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         16'd6,  16'd4};
    vecs[6]  = '{1'b1, 32'h2000_0000, 1'b1, 1'b0, 32'h1234_0004, 32'h2000_0000, 1'b1, 32'h1234_0008, 1'b0, 1'b0, 32'h0,         32'h0,         16'd7,  16'd5};
    vecs[7]  = '{1'b1, 32'h2000_0000, 1'b1, 1'b1, 32'h1234_0004, 32'h2000_0000, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         16'd8,  16'd5};
    vecs[8]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h1234_0008, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         16'd9,  16'd5};
    vecs[9]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h1234_0008, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         16'd9,  16'd5};
    vecs[10] = '{1'b1, 32'h5555_0000, 1'b0, 1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h0000_1004, 1'b1, 1'b1, 32'h0000_1000, 32'h0,         16'd9,  16'd6};
    vecs[11] = '{1'b1, 32'h5555_0000, 1'b1, 1'b0, 32'h1234_0000, 32'h0,         1'b1, 32'h1234_0004, 1'b1, 1'b1, 32'h1234_0000, 32'h0,         16'd10, 16'd7};

    // Reset
    rst   = 1'b1;
    PC    = 32'h0;
    PC_Ex = 32'h0;
    idle_inputs();
    repeat (3) tick();
    check_out("reset", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 16'd0, 16'd0);
    rst = 1'b0;
    tick();
    check_out("reset.idle", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 16'd0, 16'd0);

    // Table vectors
    for (int i = 0; i < 12; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Stall with a hit held in IF/ID: bubble reaches EX, resolves once later.
    idle_inputs();
    Hit        = 1'b1;
    Target_Add = 32'h3000_0000;
    tick();
    idle_inputs();
    Stall_Detected = 1'b1;
    tick();
    check_out("stall.c1", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 16'd10, 16'd7);
    Br_Detected = 1'b1;
    Taken_Ex    = 1'b0;
    PC_Ex       = 32'h1234_0008;
    tick();
    check_out("stall.bubble", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 16'd10, 16'd7);
    Stall_Detected = 1'b0;
    Br_Detected    = 1'b0;
    tick();
    check_out("stall.release", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 16'd10, 16'd7);
    Stall_Detected = 1'b1;  // coincident stall must not block resolution
    Br_Detected    = 1'b1;
    Taken_Ex       = 1'b0;
    PC_Ex          = 32'h1234_0008;
    tick();
    check_out("stall.resolve", 1'b1, 32'h1234_000C, 1'b1, 1'b1, 32'h1234_0008, 32'h0, 16'd11, 16'd8);
    idle_inputs();
    tick();
    check_out("stall.after", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 16'd11, 16'd8);

    // Mispredict followed by a wrong-path hit in EX during the Flush cycle.
    idle_inputs();
    tick();
    Hit        = 1'b1;
    Target_Add = 32'h4000_0000;
    tick();
    check_out("gate.pre", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 16'd11, 16'd8);
    idle_inputs();
    Br_Detected = 1'b1;
    Taken_Ex    = 1'b1;
    PC_Ex       = 32'h1234_0010;
    PC_ALU      = 32'h6000_0000;
    tick();
    check_out("gate.mispred", 1'b1, 32'h6000_0000, 1'b1, 1'b0, 32'h1234_0010, 32'h6000_0000, 16'd12, 16'd9);
    Br_Detected = 1'b1;
    Taken_Ex    = 1'b0;
    PC_Ex       = 32'h1234_0014;
    PC_ALU      = 32'h0;
    tick();
    check_out("gate.wrongpath", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 16'd12, 16'd9);
    idle_inputs();
    tick();

    // Alias hit at top of address space, then reset during the Flush cycle.
    idle_inputs();
    Hit        = 1'b1;
    Target_Add = 32'h0000_0100;
    tick();
    idle_inputs();
    tick();
    Br_Detected = 1'b0;
    PC_Ex       = 32'hFFFF_FFFC;
    tick();
    check_out("alias.wrap", 1'b1, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0, 16'd12, 16'd10);
    rst = 1'b1;
    idle_inputs();
    tick();
    check_out("alias.rst", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 16'd0, 16'd0);
    check("alias.rst.Upd_Inval", 32'(Upd_Inval), 32'h0);
    check("alias.rst.Redirect_PC", Redirect_PC, 32'h0);
    rst = 1'b0;

    // Entry for index 1 was at strongly-taken before reset; after reset it
    // must start from zero, so a not-taken hit invalidates immediately.
    begin
      vec_t v;
      v = '{1'b1, 32'h2000_0000, 1'b1, 1'b0, 32'h1234_0004, 32'h0, 1'b1, 32'h1234_0008,
            1'b1, 1'b1, 32'h1234_0004, 32'h0, 16'd1, 16'd1};
      run_vec("postrst", v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_branch_resolve_unit
`default_nettype wire
